// File: rtl/ir_fetch.sv
// ----------------------------------------------------------------------------
// ir_fetch -- LC-3b instruction-fetch sequencer.
//
// On a start request in IDLE, reads one 16-bit word from memory at the
// supplied PC using the MIO ready handshake. It then presents that word on
// ir_data with a single-cycle ir_load strobe, together with PC+2 on pc_next.
//
// Parameters
//   TIMEOUT   max cycles spent in REQ without mem_r before the fetch is
//             aborted with an err pulse; 0 waits forever.
//
// Ports
//   clk       system clock, rising-edge
//   reset     synchronous, active-high reset
//   start     fetch request (sampled only in IDLE)
//   flush     abort an in-flight fetch (REQ only)
//   pc_in     fetch address, sampled with start
//   mem_addr  memory address (MAR), valid while mem_en=1
//   mem_en    memory read enable
//   mem_r     memory ready; mem_data valid in the same cycle
//   mem_data  memory read data
//   ir_load   one-cycle IR load strobe
//   ir_data   fetched instruction word (MDR), qualified by ir_load
//   pc_next   fetch address + 2, qualified by ir_load
//   busy      high in any state other than IDLE
//   err       one-cycle pulse: unaligned PC or memory timeout
//
// All outputs are driven from registers only; there is no combinational
// path from any input to any output.
// ----------------------------------------------------------------------------
module ir_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] pc_in,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    input  logic        mem_r,
    input  logic [15:0] mem_data,
    output logic        ir_load,
    output logic [15:0] ir_data,
    output logic [15:0] pc_next,
    output logic        busy,
    output logic        err
);

    // The counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [15:0]   addr_reg,  addr_next;
    logic [15:0]   mdr_reg,   mdr_next;
    logic [15:0]   npc_reg,   npc_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic          err_reg,   err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            mdr_reg   <= '0;
            npc_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            mdr_reg   <= mdr_next;
            npc_reg   <= npc_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        mdr_next   = mdr_reg;
        npc_next   = npc_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (pc_in[0]) begin
                        // Unaligned word fetch: report it, never touch memory.
                        err_next = 1'b1;
                    end else begin
                        addr_next  = pc_in;
                        cnt_next   = '0;
                        state_next = REQ;
                    end
                end
            end

            REQ: begin
                // flush beats a same-cycle mem_r and a same-cycle timeout.
                if (flush) begin
                    state_next = IDLE;
                end else if (mem_r) begin
                    mdr_next   = mem_data;
                    // PC+2 is precomputed here so pc_next is a plain register.
                    npc_next   = addr_reg + 16'd2;
                    state_next = LOAD;
                end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            LOAD: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_en   = (state_reg == REQ);
    assign mem_addr = addr_reg;
    assign ir_load  = (state_reg == LOAD);
    assign ir_data  = mdr_reg;
    assign pc_next  = npc_reg;
    assign busy     = (state_reg != IDLE);
    assign err      = err_reg;

endmodule

// File: tb/tb_ir_fetch.sv
// ----------------------------------------------------------------------------
// tb_ir_fetch -- self-checking bench for ir_fetch.
//
// Two instances share one set of inputs: one with the default timeout (16)
// and one with TIMEOUT=4. A transaction-level model predicts both every cycle;
// a negedge process compares. Directed sequences pin literal values first,
// then a long randomized run exercises starts, stalls, flushes and resets.
// ----------------------------------------------------------------------------
module tb_ir_fetch;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [15:0] pc_in;
    logic        mem_r;
    logic [15:0] mem_data;

    logic [15:0] a_mem_addr, b_mem_addr;
    logic        a_mem_en,   b_mem_en;
    logic        a_ir_load,  b_ir_load;
    logic [15:0] a_ir_data,  b_ir_data;
    logic [15:0] a_pc_next,  b_pc_next;
    logic        a_busy,     b_busy;
    logic        a_err,      b_err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    ir_fetch #(.TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .pc_in(pc_in),
        .mem_addr(a_mem_addr), .mem_en(a_mem_en), .mem_r(mem_r), .mem_data(mem_data),
        .ir_load(a_ir_load), .ir_data(a_ir_data), .pc_next(a_pc_next),
        .busy(a_busy), .err(a_err)
    );

    ir_fetch #(.TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .pc_in(pc_in),
        .mem_addr(b_mem_addr), .mem_en(b_mem_en), .mem_r(mem_r), .mem_data(mem_data),
        .ir_load(b_ir_load), .ir_data(b_ir_data), .pc_next(b_pc_next),
        .busy(b_busy), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a fetch is "waiting for memory" or "about
    // to be delivered"; it tracks how many stall cycles have elapsed.
    // ------------------------------------------------------------------
    int          to_val [2] = '{16, 4};
    bit          m_fetch [2];
    bit          m_load  [2];
    bit          m_err   [2];
    logic [15:0] m_addr  [2];
    logic [15:0] m_mdr   [2];
    logic [15:0] m_npc   [2];
    int          m_waited[2];

    always @(posedge clk) begin
        for (int t = 0; t < 2; t++) begin
            if (reset) begin
                m_fetch[t]  <= 1'b0;
                m_load[t]   <= 1'b0;
                m_err[t]    <= 1'b0;
                m_addr[t]   <= 16'h0000;
                m_mdr[t]    <= 16'h0000;
                m_npc[t]    <= 16'h0000;
                m_waited[t] <= 0;
            end else begin
                m_err[t] <= 1'b0;
                if (m_load[t]) begin
                    m_load[t] <= 1'b0;
                end else if (m_fetch[t]) begin
                    if (flush) begin
                        m_fetch[t] <= 1'b0;
                    end else if (mem_r) begin
                        m_mdr[t]   <= mem_data;
                        m_npc[t]   <= 16'(m_addr[t] + 16'd2);
                        m_fetch[t] <= 1'b0;
                        m_load[t]  <= 1'b1;
                    end else if (to_val[t] != 0 && m_waited[t] + 1 == to_val[t]) begin
                        // This was the TIMEOUT-th cycle spent waiting.
                        m_err[t]   <= 1'b1;
                        m_fetch[t] <= 1'b0;
                    end else begin
                        m_waited[t] <= m_waited[t] + 1;
                    end
                end else if (start) begin
                    if (pc_in[0]) begin
                        m_err[t] <= 1'b1;
                    end else begin
                        m_addr[t]   <= pc_in;
                        m_waited[t] <= 0;
                        m_fetch[t]  <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic compare_dut(input int t, input string tag,
                               input logic en, input logic [15:0] addr,
                               input logic ld, input logic [15:0] dat,
                               input logic [15:0] npc, input logic bsy, input logic er);
        check({tag, ".mem_en"},  16'(en),  16'(m_fetch[t]));
        if (m_fetch[t])
            check({tag, ".mem_addr"}, addr, m_addr[t]);
        check({tag, ".ir_load"}, 16'(ld),  16'(m_load[t]));
        check({tag, ".ir_data"}, dat,      m_mdr[t]);
        check({tag, ".pc_next"}, npc,      m_npc[t]);
        check({tag, ".busy"},    16'(bsy), 16'(m_fetch[t] | m_load[t]));
        check({tag, ".err"},     16'(er),  16'(m_err[t]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            compare_dut(0, "a", a_mem_en, a_mem_addr, a_ir_load, a_ir_data, a_pc_next, a_busy, a_err);
            compare_dut(1, "b", b_mem_en, b_mem_addr, b_ir_load, b_ir_data, b_pc_next, b_busy, b_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;
    int load_cnt;
    int en_cnt;
    bit addr_ok;

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; pc_in = 16'h0000;
        mem_r = 1'b0; mem_data = 16'h0000;
        tick(); tick();

        // Reset state
        check("rst.mem_en",   16'(a_mem_en),  16'h0);
        check("rst.ir_load",  16'(a_ir_load), 16'h0);
        check("rst.busy",     16'(a_busy),    16'h0);
        check("rst.err",      16'(a_err),     16'h0);
        check("rst.mem_addr", a_mem_addr,     16'h0000);
        check("rst.ir_data",  a_ir_data,      16'h0000);
        check("rst.pc_next",  a_pc_next,      16'h0000);
        reset = 1'b0;
        cmp_en = 1'b1;

        // 1: minimum-latency fetch
        start = 1'b1; pc_in = 16'h3000; mem_r = 1'b1; mem_data = 16'h1234;
        tick();
        start = 1'b0;
        check("t1.c1.mem_en",   16'(a_mem_en), 16'h1);
        check("t1.c1.mem_addr", a_mem_addr,    16'h3000);
        tick();
        mem_r = 1'b0;
        check("t1.c2.ir_load",  16'(a_ir_load), 16'h1);
        check("t1.c2.ir_data",  a_ir_data,      16'h1234);
        check("t1.c2.pc_next",  a_pc_next,      16'h3002);
        check("t1.c2.mem_en",   16'(a_mem_en),  16'h0);
        tick();
        check("t1.c3.busy",     16'(a_busy),    16'h0);
        $display("txn t1: fetch 3000 -> 1234");

        // 2: five stall cycles
        start = 1'b1; pc_in = 16'h4000; mem_r = 1'b0; mem_data = 16'hABCD;
        busy_cnt = 0; load_cnt = 0; addr_ok = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            mem_r = (c == 6);
            busy_cnt += int'(a_busy);
            load_cnt += int'(a_ir_load);
            if (a_mem_en && a_mem_addr !== 16'h4000) addr_ok = 1'b0;
            if (a_ir_load) check("t2.ir_data", a_ir_data, 16'hABCD);
        end
        check("t2.busy_cycles", 16'(busy_cnt), 16'd7);
        check("t2.loads",       16'(load_cnt), 16'd1);
        check("t2.addr_stable", 16'(addr_ok),  16'h1);
        $display("txn t2: stalled fetch 4000 -> ABCD");

        // 3: unaligned PC
        start = 1'b1; pc_in = 16'h3001;
        tick();
        start = 1'b0;
        check("t3.err",    16'(a_err),    16'h1);
        check("t3.mem_en", 16'(a_mem_en), 16'h0);
        check("t3.busy",   16'(a_busy),   16'h0);
        tick();
        check("t3.err_off", 16'(a_err),  16'h0);
        $display("txn t3: unaligned 3001 -> err");

        // 4: timeout on the TIMEOUT=4 instance
        start = 1'b1; pc_in = 16'h2000; mem_r = 1'b0;
        en_cnt = 0; load_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0;
            en_cnt += int'(b_mem_en);
            load_cnt += int'(b_ir_load);
            if (c == 5) check("t4.err", 16'(b_err), 16'h1);
        end
        check("t4.en_cycles", 16'(en_cnt),   16'd4);
        check("t4.loads",     16'(load_cnt), 16'd0);
        check("t4.idle",      16'(b_busy),   16'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4.flush_a", 16'(a_busy), 16'h0);
        $display("txn t4: timeout 2000 -> err");

        // 5: flush and mem_r in the same REQ cycle, then a normal fetch
        start = 1'b1; pc_in = 16'h1000;
        tick();
        start = 1'b0; flush = 1'b1; mem_r = 1'b1; mem_data = 16'hDEAD;
        tick();
        check("t5.busy",    16'(a_busy),    16'h0);
        check("t5.ir_load", 16'(a_ir_load), 16'h0);
        check("t5.err",     16'(a_err),     16'h0);
        flush = 1'b0; start = 1'b1; pc_in = 16'h5000; mem_r = 1'b1; mem_data = 16'h5A5A;
        tick();
        start = 1'b0;
        check("t5.mem_addr", a_mem_addr, 16'h5000);
        tick();
        mem_r = 1'b0;
        check("t5.ir_load2", 16'(a_ir_load), 16'h1);
        check("t5.ir_data",  a_ir_data,      16'h5A5A);
        check("t5.pc_next",  a_pc_next,      16'h5002);
        tick();
        $display("txn t5: flush race, then fetch 5000 -> 5A5A");

        // 6: wrap-around, then reset mid-REQ
        start = 1'b1; pc_in = 16'hFFFE; mem_r = 1'b1; mem_data = 16'h0F0F;
        tick();
        start = 1'b0;
        tick();
        mem_r = 1'b0;
        check("t6.ir_load", 16'(a_ir_load), 16'h1);
        check("t6.pc_next", a_pc_next,      16'h0000);
        tick();
        $display("txn t6a: fetch FFFE -> pc_next 0000");

        start = 1'b1; pc_in = 16'h6000; mem_r = 1'b0;
        tick();
        start = 1'b0; reset = 1'b1; mem_r = 1'b1; mem_data = 16'h7777;
        tick();
        check("t6.rst.mem_en",   16'(a_mem_en),  16'h0);
        check("t6.rst.ir_load",  16'(a_ir_load), 16'h0);
        check("t6.rst.busy",     16'(a_busy),    16'h0);
        check("t6.rst.err",      16'(a_err),     16'h0);
        check("t6.rst.mem_addr", a_mem_addr,     16'h0000);
        check("t6.rst.ir_data",  a_ir_data,      16'h0000);
        check("t6.rst.pc_next",  a_pc_next,      16'h0000);
        reset = 1'b0;
        load_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            load_cnt += int'(a_ir_load);
        end
        mem_r = 1'b0;
        check("t6.no_load_after_reset", 16'(load_cnt), 16'd0);
        $display("txn t6b: reset mid-REQ");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            mem_r    = ($urandom_range(0, 3) == 0);
            mem_data = 16'($urandom);
            pc_in    = 16'($urandom);
            pc_in[0] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) pc_in = 16'hFFFE;
            tick();
        end
        reset = 1'b0; start = 1'b0; flush = 1'b0; mem_r = 1'b0;
        tick(); tick();
        $display("txn random: 3000 cycles");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
